frame_sync_gen: RTL

- Produces the frame_sync level that the CPU polls through the frame-sync PIO input port.
- Detects start-of-frame on the VGA controller's active-low vsync and holds frame_sync high until software acknowledges it or a timeout expires.
- Also keeps a frame counter and a missed-frame (overrun) counter for debug readout.
- Sits between the VGA controller and the frame-sync PIO in the SoC top level.

---
 rtl/frame_sync_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frame_sync_gen.sv
// Frame-sync flag generator: turns the VGA vsync falling edge into a
// sticky frame_sync level for the CPU, plus frame and overrun counters.
module frame_sync_gen #(
   parameter int CNT_W      = 16,
   parameter int AUTO_CLEAR = 0,
   parameter int TMR_W      = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             vs,
   input  logic             frame_ack,
   input  logic             stat_clr,
   output logic             frame_sync,
   output logic [CNT_W-1:0] frame_count,
   output logic [7:0]       overrun_cnt
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [TMR_W-1:0] TMR_MAX = '1;
   localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(AUTO_CLEAR - 1);
   localparam bit               TMO_EN  = (AUTO_CLEAR != 0);

   state_t           state;
   logic [TMR_W-1:0] timer;

   logic sync1;
   logic sync2;
   logic vs_d;
   logic ack_s1;
   logic ack_s2;
   logic ack_d;

   logic sof;
   logic ack_rise;
   logic tmo;
   logic inc_ovr;

   // Synchronizers start high on vs so no false falling edge follows reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         vs_d   <= 1'b1;
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_d  <= 1'b0;
      end else begin
         sync1  <= vs;
         sync2  <= sync1;
         vs_d   <= sync2;
         ack_s1 <= frame_ack;
         ack_s2 <= ack_s1;
         ack_d  <= ack_s2;
      end
   end

   assign sof      = vs_d & ~sync2;
   assign ack_rise = ack_s2 & ~ack_d;
   assign tmo      = TMO_EN && (timer == TMO_VAL);
   assign inc_ovr  = sof && (state == PEND) && !ack_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         frame_sync <= 1'b0;
         timer      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (sof) begin
                  state      <= PEND;
                  frame_sync <= 1'b1;
                  timer      <= '0;
               end
            end
            PEND: begin
               if (ack_rise && !sof) begin
                  state      <= IDLE;
                  frame_sync <= 1'b0;
                  timer      <= '0;
               end else if (ack_rise && sof) begin
                  timer <= '0;
               end else if (tmo && !sof) begin
                  state      <= IDLE;
                  frame_sync <= 1'b0;
                  timer      <= '0;
               end else if (timer != TMR_MAX) begin
                  // overrun sofs leave the timeout running from the first frame
                  timer <= timer + TMR_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               frame_sync <= 1'b0;
               timer      <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= '0;
         overrun_cnt <= '0;
      end else if (stat_clr) begin
         frame_count <= '0;
         overrun_cnt <= '0;
      end else begin
         if (sof) begin
            frame_count <= frame_count + CNT_W'(1);
         end
         if (inc_ovr && (overrun_cnt != 8'hff)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

endmodule
